atm_session_ctrl: RTL and testbench
===================================

ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

Interface
REQ-001 SHALL have parameter MAX_PIN_TRIES, default 3, PIN failures before lockout (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, idle cycles before session abort (legal range >= 2).
REQ-003 SHALL have parameter LOCK_CYCLES, default 64, lockout duration in cycles (legal range >= 1).
REQ-004 SHALL have parameter TIMER_W, default 16, width of the timeout/lock counter; must hold max(TIMEOUT_CYCLES, LOCK_CYCLES).
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 status_code  in  4  event code: 0 none, 1 ACC_FOUND, 2 ACC_NOT_FOUND, 3 PIN_CORRECT, 4 PIN_INCORRECT, 5 AMT_VALID, 6 AMT_INVALID, 7 EXIT, 8 INPUT_COMPLETE; 9-15 ignored.
REQ-008 usr_input  in  2  menu choice: 0 BALANCE, 1 CONVERT, 2 WITHDRAW, 3 TRANSFER.
REQ-009 usr_valid  in  1  one-cycle strobe qualifying usr_input.
REQ-010 current_state  out  4  registered state encoding (REQ-016).
REQ-011 state_led  out  16  one-hot, bit[current_state] set, all others 0.
REQ-012 input_style_out  out  4  expected input: 0 none, 1 account, 2 PIN, 3 menu select, 4 amount, 5 destination account.
REQ-013 op_out  out  2  latched menu choice of the current transaction.
REQ-014 result_ok / result_err  out  1 each  one-cycle pulses on entry to RESULT.
REQ-015 timeout_pulse  out  1; locked  out  1; tries_left  out  4.

Function
REQ-016 States: IDLE=0, ACC_CHECK=1, PIN_INPUT=2, MENU=3, BALANCE=4, DEST_ACC=5, AMOUNT=6, AMT_CHECK=7, RESULT=8, LOCKED=9; encodings 10-15 unused, recover to IDLE next cycle.
REQ-017 IDLE: INPUT_COMPLETE -> ACC_CHECK.
REQ-018 ACC_CHECK: ACC_FOUND -> PIN_INPUT, tries_left loaded with MAX_PIN_TRIES; ACC_NOT_FOUND or EXIT -> IDLE.
REQ-019 PIN_INPUT: PIN_CORRECT -> MENU; PIN_INCORRECT decrements tries_left, -> LOCKED when result is 0, else stays; EXIT -> IDLE.
REQ-020 MENU: usr_valid latches usr_input into op_out; BALANCE -> BALANCE, CONVERT/WITHDRAW -> AMOUNT, TRANSFER -> DEST_ACC; EXIT -> IDLE; EXIT wins over simultaneous usr_valid.
REQ-021 DEST_ACC: ACC_FOUND -> AMOUNT; ACC_NOT_FOUND -> RESULT with result_err.
REQ-022 AMOUNT: INPUT_COMPLETE -> AMT_CHECK. AMT_CHECK: AMT_VALID -> RESULT with result_ok; AMT_INVALID -> RESULT with result_err.
REQ-023 BALANCE, RESULT: EXIT -> MENU. DEST_ACC, AMOUNT, AMT_CHECK: EXIT -> MENU, no result pulse.
REQ-024 Codes not listed for the current state, and usr_valid outside MENU, SHALL be ignored (no state change, timer not cleared).
REQ-025 Timeout: in every state except IDLE and LOCKED, counter increments each cycle without an accepted event; accepted event or state change clears it; at TIMEOUT_CYCLES-1 next state is IDLE and timeout_pulse asserts for one cycle coincident with IDLE entry.
REQ-026 LOCKED: locked=1; counter runs LOCK_CYCLES cycles, then -> IDLE; all inputs ignored, including EXIT.
REQ-027 State transition latency exactly one clk after the qualifying input is sampled; outputs are registered, no combinational input-to-output paths.
REQ-028 tries_left SHALL not underflow; MAX_PIN_TRIES=1 locks on first PIN_INCORRECT.

Reset
REQ-029 rst asserted SHALL immediately force: current_state=IDLE, state_led=16'h0001, input_style_out=1, op_out=0, result_ok=result_err=0, timeout_pulse=0, locked=0, tries_left=MAX_PIN_TRIES, counter=0.
REQ-030 rst mid-session or mid-lockout SHALL abandon the session; no pulse output after release.

Verification
REQ-031 Login: INPUT_COMPLETE, ACC_FOUND, PIN_CORRECT on consecutive cycles -> states 1,2,3; state_led 0x0002,0x0004,0x0008.
REQ-032 Lockout (default): login to PIN_INPUT, 3x PIN_INCORRECT -> tries_left 2,1, then LOCKED, locked=1 for 64 cycles, then IDLE; EXIT during lock ignored.
REQ-033 Transfer: MENU, usr_valid with usr_input=3 -> DEST_ACC, op_out=3; ACC_FOUND, INPUT_COMPLETE, AMT_VALID -> RESULT, result_ok one cycle; EXIT -> MENU. Repeat with ACC_NOT_FOUND -> result_err.
REQ-034 Timeout: TIMEOUT_CYCLES=10, sit in MENU with status_code=0 -> IDLE after 10 cycles, timeout_pulse one cycle; an event at cycle 9 restarts the count.
REQ-035 Priority/reset: in MENU drive EXIT with usr_valid=1 -> IDLE, op_out unchanged; assert rst in AMT_CHECK -> all outputs at REQ-029 values same cycle.

Source files
------------

// File: rtl/atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : atm_session_ctrl
// Purpose  : ATM session sequencer.
//            Steps through account lookup, PIN entry with lockout, menu
//            selection, destination/amount entry and result reporting.
//            An idle timeout returns any active session to IDLE.
// Ports    : clk             - clock, rising edge
//            rst             - asynchronous active-high reset
//            status_code[3:0]- event code from the host/back end
//            usr_input[1:0]  - menu choice, qualified by usr_valid
//            usr_valid       - one-cycle strobe for usr_input
//            current_state   - registered state encoding
//            state_led[15:0] - one-hot copy of current_state
//            input_style_out - kind of input the session is waiting for
//            op_out          - menu choice latched for this transaction
//            result_ok/err   - one-cycle pulses on RESULT entry
//            timeout_pulse   - one-cycle pulse on timeout-driven IDLE entry
//            locked          - high while in LOCKED
//            tries_left      - remaining PIN attempts
// Revision : 1.0 - initial release
// ============================================================================
module atm_session_ctrl #(
  parameter int MAX_PIN_TRIES  = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int LOCK_CYCLES    = 64,
  parameter int TIMER_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  status_code,
  input  logic [1:0]  usr_input,
  input  logic        usr_valid,
  output logic [3:0]  current_state,
  output logic [15:0] state_led,
  output logic [3:0]  input_style_out,
  output logic [1:0]  op_out,
  output logic        result_ok,
  output logic        result_err,
  output logic        timeout_pulse,
  output logic        locked,
  output logic [3:0]  tries_left
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ACC_CHECK = 4'd1;
  localparam logic [3:0] S_PIN_INPUT = 4'd2;
  localparam logic [3:0] S_MENU      = 4'd3;
  localparam logic [3:0] S_BALANCE   = 4'd4;
  localparam logic [3:0] S_DEST_ACC  = 4'd5;
  localparam logic [3:0] S_AMOUNT    = 4'd6;
  localparam logic [3:0] S_AMT_CHECK = 4'd7;
  localparam logic [3:0] S_RESULT    = 4'd8;
  localparam logic [3:0] S_LOCKED    = 4'd9;

  localparam logic [3:0] EV_ACC_FOUND      = 4'd1;
  localparam logic [3:0] EV_ACC_NOT_FOUND  = 4'd2;
  localparam logic [3:0] EV_PIN_CORRECT    = 4'd3;
  localparam logic [3:0] EV_PIN_INCORRECT  = 4'd4;
  localparam logic [3:0] EV_AMT_VALID      = 4'd5;
  localparam logic [3:0] EV_AMT_INVALID    = 4'd6;
  localparam logic [3:0] EV_EXIT           = 4'd7;
  localparam logic [3:0] EV_INPUT_COMPLETE = 4'd8;

  localparam logic [1:0] OP_BALANCE  = 2'd0;
  localparam logic [1:0] OP_TRANSFER = 2'd3;

  localparam logic [3:0]         TRIES_INIT   = 4'(MAX_PIN_TRIES);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST    = TIMER_W'(LOCK_CYCLES - 1);

  logic [3:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         tries_q, tries_d;
  logic [1:0]         op_q, op_d;
  logic               result_ok_q, result_ok_d;
  logic               result_err_q, result_err_d;
  logic               timeout_q, timeout_d;
  logic               locked_q, locked_d;
  logic [15:0]        state_led_q, state_led_d;
  logic [3:0]         input_style_q, input_style_d;
  logic               accept;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    tries_d      = tries_q;
    op_d         = op_q;
    result_ok_d  = 1'b0;
    result_err_d = 1'b0;
    timeout_d    = 1'b0;
    accept       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (status_code == EV_INPUT_COMPLETE) begin
          state_d = S_ACC_CHECK; accept = 1'b1;
        end
      end
      S_ACC_CHECK: begin
        if (status_code == EV_ACC_FOUND) begin
          state_d = S_PIN_INPUT; tries_d = TRIES_INIT; accept = 1'b1;
        end else if (status_code == EV_ACC_NOT_FOUND || status_code == EV_EXIT) begin
          state_d = S_IDLE; accept = 1'b1;
        end
      end
      S_PIN_INPUT: begin
        if (status_code == EV_PIN_CORRECT) begin
          state_d = S_MENU; accept = 1'b1;
        end else if (status_code == EV_PIN_INCORRECT) begin
          accept = 1'b1;
          // Saturating decrement: the last attempt locks instead of wrapping.
          if (tries_q <= 4'd1) begin
            tries_d = 4'd0; state_d = S_LOCKED;
          end else begin
            tries_d = tries_q - 4'd1;
          end
        end else if (status_code == EV_EXIT) begin
          state_d = S_IDLE; accept = 1'b1;
        end
      end
      S_MENU: begin
        // EXIT takes priority over a menu strobe in the same cycle.
        if (status_code == EV_EXIT) begin
          state_d = S_IDLE; accept = 1'b1;
        end else if (usr_valid) begin
          accept = 1'b1;
          op_d   = usr_input;
          if (usr_input == OP_BALANCE)       state_d = S_BALANCE;
          else if (usr_input == OP_TRANSFER) state_d = S_DEST_ACC;
          else                               state_d = S_AMOUNT;
        end
      end
      S_BALANCE, S_RESULT: begin
        if (status_code == EV_EXIT) begin
          state_d = S_MENU; accept = 1'b1;
        end
      end
      S_DEST_ACC: begin
        if (status_code == EV_ACC_FOUND) begin
          state_d = S_AMOUNT; accept = 1'b1;
        end else if (status_code == EV_ACC_NOT_FOUND) begin
          state_d = S_RESULT; result_err_d = 1'b1; accept = 1'b1;
        end else if (status_code == EV_EXIT) begin
          state_d = S_MENU; accept = 1'b1;
        end
      end
      S_AMOUNT: begin
        if (status_code == EV_INPUT_COMPLETE) begin
          state_d = S_AMT_CHECK; accept = 1'b1;
        end else if (status_code == EV_EXIT) begin
          state_d = S_MENU; accept = 1'b1;
        end
      end
      S_AMT_CHECK: begin
        if (status_code == EV_AMT_VALID) begin
          state_d = S_RESULT; result_ok_d = 1'b1; accept = 1'b1;
        end else if (status_code == EV_AMT_INVALID) begin
          state_d = S_RESULT; result_err_d = 1'b1; accept = 1'b1;
        end else if (status_code == EV_EXIT) begin
          state_d = S_MENU; accept = 1'b1;
        end
      end
      S_LOCKED: begin
        // Every input is ignored; only the lock timer below leaves this state.
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared counter: lock duration in LOCKED, inactivity timeout elsewhere.
    if (state_q == S_LOCKED) begin
      if (timer_q == LOCK_LAST) begin
        state_d = S_IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TIMER_W'(1);
      end
    end else if (state_q == S_IDLE || state_q > S_LOCKED || accept) begin
      timer_d = '0;
    end else if (timer_q == TIMEOUT_LAST) begin
      state_d   = S_IDLE;
      timeout_d = 1'b1;
      timer_d   = '0;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end

    // Outputs are registered from the next-state value so they line up with
    // current_state without any combinational path from the inputs.
    state_led_d = 16'h0001 << state_d;
    locked_d    = (state_d == S_LOCKED);
    case (state_d)
      S_IDLE:      input_style_d = 4'd1;
      S_PIN_INPUT: input_style_d = 4'd2;
      S_MENU:      input_style_d = 4'd3;
      S_AMOUNT:    input_style_d = 4'd4;
      S_DEST_ACC:  input_style_d = 4'd5;
      default:     input_style_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      tries_q       <= TRIES_INIT;
      op_q          <= 2'd0;
      result_ok_q   <= 1'b0;
      result_err_q  <= 1'b0;
      timeout_q     <= 1'b0;
      locked_q      <= 1'b0;
      state_led_q   <= 16'h0001;
      input_style_q <= 4'd1;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      tries_q       <= tries_d;
      op_q          <= op_d;
      result_ok_q   <= result_ok_d;
      result_err_q  <= result_err_d;
      timeout_q     <= timeout_d;
      locked_q      <= locked_d;
      state_led_q   <= state_led_d;
      input_style_q <= input_style_d;
    end
  end

  assign current_state   = state_q;
  assign state_led       = state_led_q;
  assign input_style_out = input_style_q;
  assign op_out          = op_q;
  assign result_ok       = result_ok_q;
  assign result_err      = result_err_q;
  assign timeout_pulse   = timeout_q;
  assign locked          = locked_q;
  assign tries_left      = tries_q;

endmodule
`default_nettype wire

// File: tb/tb_atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_atm_session_ctrl
// Purpose  : Scoreboard bench for atm_session_ctrl. Stimulus pushes the
//            expected output vector for the cycle after each drive; a
//            monitor pops and compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atm_session_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  status_code = 4'd0;
  logic [1:0]  usr_input = 2'd0;
  logic        usr_valid = 1'b0;
  logic [3:0]  current_state;
  logic [15:0] state_led;
  logic [3:0]  input_style_out;
  logic [1:0]  op_out;
  logic        result_ok, result_err, timeout_pulse, locked;
  logic [3:0]  tries_left;

  atm_session_ctrl #(
    .MAX_PIN_TRIES (3),
    .TIMEOUT_CYCLES(10),
    .LOCK_CYCLES   (64),
    .TIMER_W       (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .status_code    (status_code),
    .usr_input      (usr_input),
    .usr_valid      (usr_valid),
    .current_state  (current_state),
    .state_led      (state_led),
    .input_style_out(input_style_out),
    .op_out         (op_out),
    .result_ok      (result_ok),
    .result_err     (result_err),
    .timeout_pulse  (timeout_pulse),
    .locked         (locked),
    .tries_left     (tries_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          tgt;
    logic [33:0] v;
    string       nm;
  } exp_t;
  exp_t sb[$];

  // Expected op_out / tries_left, set by hand as the stimulus proceeds.
  logic [1:0] e_op = 2'd0;
  logic [3:0] e_tr = 4'd3;

  logic [33:0] act;
  assign act = {current_state, state_led, input_style_out, op_out,
                result_ok, result_err, timeout_pulse, locked, tries_left};

  function automatic logic [3:0] style_of(input logic [3:0] st);
    case (st)
      4'd0:    return 4'd1;
      4'd2:    return 4'd2;
      4'd3:    return 4'd3;
      4'd6:    return 4'd4;
      4'd5:    return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [33:0] pack(input logic [3:0] st, input logic ok,
                                       input logic err, input logic to);
    logic [15:0] led;
    led = 16'h0001 << st;
    return {st, led, style_of(st), e_op, ok, err, to, (st == 4'd9), e_tr};
  endfunction

  task automatic check(input string nm, input logic [33:0] got, input logic [33:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {st,led,sty,op,ok,err,to,lk,tr}=%h required %h", nm, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] code, input logic uv, input logic [1:0] ui,
                      input logic [3:0] st, input logic ok, input logic err,
                      input logic to, input string nm);
    exp_t e;
    @(negedge clk);
    status_code = code;
    usr_valid   = uv;
    usr_input   = ui;
    e.tgt = cyc + 1;
    e.v   = pack(st, ok, err, to);
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [3:0] st, input string nm);
    step(4'd0, 1'b0, 2'd0, st, 1'b0, 1'b0, 1'b0, nm);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      e = sb.pop_front();
      check(e.nm, act, e.v);
    end
  end

  initial begin
    rst = 1'b0;
    #2 rst = 1'b1;
    #1 check("reset_async", act, pack(4'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(4'd0, "reset_idle");

    // Login
    step(4'd8, 0, 0, 4'd1, 0, 0, 0, "login_acc_check");
    step(4'd1, 0, 0, 4'd2, 0, 0, 0, "login_pin");
    step(4'd3, 0, 0, 4'd3, 0, 0, 0, "login_menu");

    // Transfer, success
    e_op = 2'd3;
    step(4'd0, 1, 2'd3, 4'd5, 0, 0, 0, "xfer_dest");
    step(4'd1, 0, 0, 4'd6, 0, 0, 0, "xfer_amount");
    step(4'd8, 0, 0, 4'd7, 0, 0, 0, "xfer_amt_check");
    step(4'd5, 0, 0, 4'd8, 1, 0, 0, "xfer_result_ok");
    idle(4'd8, "xfer_ok_one_cycle");
    step(4'd7, 0, 0, 4'd3, 0, 0, 0, "xfer_exit_menu");

    // Transfer, destination not found
    step(4'd0, 1, 2'd3, 4'd5, 0, 0, 0, "xfer2_dest");
    step(4'd2, 0, 0, 4'd8, 0, 1, 0, "xfer2_result_err");
    idle(4'd8, "xfer2_err_one_cycle");
    step(4'd7, 0, 0, 4'd3, 0, 0, 0, "xfer2_exit_menu");

    // Unlisted code in MENU is ignored
    step(4'd5, 0, 0, 4'd3, 0, 0, 0, "menu_ignore_amt_valid");

    // Balance
    e_op = 2'd0;
    step(4'd0, 1, 2'd0, 4'd4, 0, 0, 0, "balance");
    step(4'd7, 0, 0, 4'd3, 0, 0, 0, "balance_exit");

    // Withdraw, invalid amount
    e_op = 2'd2;
    step(4'd0, 1, 2'd2, 4'd6, 0, 0, 0, "wd_amount");
    step(4'd8, 0, 0, 4'd7, 0, 0, 0, "wd_amt_check");
    step(4'd6, 0, 0, 4'd8, 0, 1, 0, "wd_amt_invalid");
    step(4'd7, 0, 0, 4'd3, 0, 0, 0, "wd_exit");

    // Convert, abandoned from AMOUNT without a result pulse
    e_op = 2'd1;
    step(4'd0, 1, 2'd1, 4'd6, 0, 0, 0, "cv_amount");
    step(4'd7, 0, 0, 4'd3, 0, 0, 0, "cv_exit_no_pulse");

    // EXIT wins over usr_valid; op_out unchanged
    step(4'd7, 1, 2'd2, 4'd0, 0, 0, 0, "exit_priority");

    // Timeout from MENU
    step(4'd8, 0, 0, 4'd1, 0, 0, 0, "to_acc_check");
    step(4'd1, 0, 0, 4'd2, 0, 0, 0, "to_pin");
    step(4'd3, 0, 0, 4'd3, 0, 0, 0, "to_menu");
    for (int i = 0; i < 9; i++) idle(4'd3, "to_menu_wait");
    step(4'd0, 0, 0, 4'd0, 0, 0, 1, "to_menu_fire");
    idle(4'd0, "to_pulse_one_cycle");

    // Event on the last timeout cycle restarts the count
    step(4'd8, 0, 0, 4'd1, 0, 0, 0, "rs_acc_check");
    step(4'd1, 0, 0, 4'd2, 0, 0, 0, "rs_pin");
    for (int i = 0; i < 9; i++) idle(4'd2, "rs_pin_wait");
    e_tr = 4'd2;
    step(4'd4, 0, 0, 4'd2, 0, 0, 0, "rs_pin_incorrect_last_cycle");
    for (int i = 0; i < 9; i++) idle(4'd2, "rs_pin_wait2");
    step(4'd0, 0, 0, 4'd0, 0, 0, 1, "rs_timeout_fire");

    // Lockout
    step(4'd8, 0, 0, 4'd1, 0, 0, 0, "lk_acc_check");
    e_tr = 4'd3;
    step(4'd1, 0, 0, 4'd2, 0, 0, 0, "lk_pin");
    e_tr = 4'd2;
    step(4'd4, 0, 0, 4'd2, 0, 0, 0, "lk_bad1");
    e_tr = 4'd1;
    step(4'd4, 0, 0, 4'd2, 0, 0, 0, "lk_bad2");
    e_tr = 4'd0;
    step(4'd4, 0, 0, 4'd9, 0, 0, 0, "lk_locked");
    for (int i = 0; i < 63; i++) begin
      if (i == 5)       step(4'd7, 0, 0, 4'd9, 0, 0, 0, "lk_exit_ignored");
      else if (i == 20) step(4'd8, 0, 0, 4'd9, 0, 0, 0, "lk_ic_ignored");
      else if (i == 30) step(4'd0, 1, 2'd0, 4'd9, 0, 0, 0, "lk_uv_ignored");
      else              idle(4'd9, "lk_hold");
    end
    idle(4'd0, "lk_release_idle");

    // Reset during AMT_CHECK
    step(4'd8, 0, 0, 4'd1, 0, 0, 0, "rr_acc_check");
    e_tr = 4'd3;
    step(4'd1, 0, 0, 4'd2, 0, 0, 0, "rr_pin");
    step(4'd3, 0, 0, 4'd3, 0, 0, 0, "rr_menu");
    e_op = 2'd2;
    step(4'd0, 1, 2'd2, 4'd6, 0, 0, 0, "rr_amount");
    step(4'd8, 0, 0, 4'd7, 0, 0, 0, "rr_amt_check");
    @(negedge clk);
    #2;
    rst = 1'b1;
    status_code = 4'd5;
    usr_valid   = 1'b0;
    #1;
    e_op = 2'd0;
    e_tr = 4'd3;
    check("rst_in_amt_check", act, pack(4'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    idle(4'd0, "rr_after_release");
    step(4'd5, 0, 0, 4'd0, 0, 0, 0, "rr_idle_ignore");

    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
